// File: rtl/tick_set_ctrl_if.sv
// tick_set_ctrl_if: raw buttons in, time-base tick / field enables / display controls out
interface tick_set_ctrl_if #(parameter int NFIELD = 6);
  logic              btn_mode_n_i;
  logic              btn_inc_n_i;
  logic              tick_o;
  logic [NFIELD-1:0] en_field_o;
  logic              set_mode_o;
  logic [2:0]        sel_field_o;
  logic              blink_o;
  modport slave  (input  btn_mode_n_i, btn_inc_n_i,
                  output tick_o, en_field_o, set_mode_o, sel_field_o, blink_o);
  modport master (output btn_mode_n_i, btn_inc_n_i,
                  input  tick_o, en_field_o, set_mode_o, sel_field_o, blink_o);
endinterface

// File: rtl/tick_set_ctrl.sv
// tick_set_ctrl: time-base tick, MODE/INC debounce and set-mode field enables; define AUTO_REPEAT_EN for INC auto-repeat
module tick_set_ctrl #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int TICK_HZ       = 1,
  parameter int DB_CYCLES     = 1_000_000,
  parameter int NFIELD        = 6,
  parameter int BLINK_DIV     = CLK_HZ / 4,
  parameter int REPEAT_DELAY  = CLK_HZ / 2,
  parameter int REPEAT_PERIOD = CLK_HZ / 8
) (
  input logic             clk,
  input logic             reset_n,
  tick_set_ctrl_if.slave  bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int DW  = $clog2(DB_CYCLES + 1);
  localparam int BW  = $clog2(BLINK_DIV + 1);
  localparam int SW  = $clog2(NFIELD + 1);
  localparam logic [SW-1:0] RUN  = '0;
  localparam logic [SW-1:0] LAST = SW'(NFIELD);
  logic [1:0]    s1_q, s2_q, db_q, ev_q;
  logic [DW-1:0] dcnt_q [2];
  logic [SW-1:0] state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    sel;
  logic          blink_q, blink_d, en_q, tick, in_set, mode_ev, inc_ev, rep_ev;
  assign mode_ev = ev_q[0];
  assign inc_ev  = ev_q[1];
  assign tick    = pcnt_q == PW'(DIV - 1);
  assign in_set  = state_q != RUN;
  // two-flop synchronisers; levels are inverted so 1 means pressed (bit 0 MODE, bit 1 INC)
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= ~{bus.btn_inc_n_i, bus.btn_mode_n_i};
      s2_q <= s1_q;
    end
  // debouncers: level flips after DB_CYCLES differing samples in a row, press edge gives a one-cycle event
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      db_q <= '0;
      ev_q <= '0;
      for (int b = 0; b < 2; b++) dcnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        ev_q[b] <= s2_q[b] & ~db_q[b] & (dcnt_q[b] == DW'(DB_CYCLES - 1));
        if (s2_q[b] == db_q[b]) dcnt_q[b] <= '0;
        else if (dcnt_q[b] == DW'(DB_CYCLES - 1)) begin
          db_q[b]   <= s2_q[b];
          dcnt_q[b] <= '0;
        end else dcnt_q[b] <= dcnt_q[b] + 1'b1;
      end
    end
  // FSM state register: 0 is RUN, k+1 is SET_k
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= RUN;
    else state_q <= state_d;
  // FSM next state: each MODE event steps RUN -> SET_0 -> ... -> SET_last -> RUN
  always_comb state_d = !mode_ev ? state_q : state_q == LAST ? RUN : state_q + 1'b1;
  // prescaler restarts on return to RUN; blink phase restarts on every state change
  always_comb begin
    pcnt_d  = (in_set && state_d == RUN) || tick ? '0 : pcnt_q + 1'b1;
    bcnt_d  = state_d != state_q || !in_set || bcnt_q == BW'(BLINK_DIV - 1) ? '0 : bcnt_q + 1'b1;
    blink_d = state_d == state_q && in_set && (blink_q ^ (bcnt_q == BW'(BLINK_DIV - 1)));
  end
  // datapath registers; an INC (or repeat) pulse is issued the cycle after its event, MODE wins a tie
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      en_q    <= in_set && !mode_ev && (inc_ev || rep_ev);
    end
`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [RW-1:0] rcnt_q;
  logic          rep_q;
  assign rep_ev = in_set && db_q[1] && !mode_ev && rcnt_q != '0 &&
                  rcnt_q == (rep_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY));
  // repeat timer: armed by an INC press in SET, counts while held, dropped on release or MODE
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rcnt_q <= '0;
      rep_q  <= 1'b0;
    end else if (in_set && inc_ev && !mode_ev) begin
      rcnt_q <= RW'(1);
      rep_q  <= 1'b0;
    end else if (!in_set || !db_q[1] || mode_ev) begin
      rcnt_q <= '0;
      rep_q  <= 1'b0;
    end else if (rep_ev) begin
      rcnt_q <= RW'(1);
      rep_q  <= 1'b1;
    end else if (rcnt_q != '0) rcnt_q <= rcnt_q + 1'b1;
`else
  assign rep_ev = 1'b0;
`endif
  // FSM outputs: tick drives field 0 in RUN, INC pulses drive the selected field in SET
  always_comb begin
    sel             = in_set ? 3'(state_q - 1'b1) : 3'd0;
    bus.tick_o      = tick;
    bus.set_mode_o  = in_set;
    bus.sel_field_o = sel;
    bus.blink_o     = blink_q;
    bus.en_field_o  = !in_set ? NFIELD'(tick) : en_q ? NFIELD'(1) << sel : '0;
  end
endmodule

// File: tb/tb_tick_set_ctrl.sv
// tb_tick_set_ctrl: directed tables plus randomized buttons against a cycle-arithmetic reference model
module tb_tick_set_ctrl;
  localparam int DIV = 20, DB = 4, NF = 6, BD = 5, RD = 10, RP = 4, NT = 13;
  logic clk = 1'b0, reset_n = 1'b0;
  tick_set_ctrl_if #(.NFIELD(NF)) bus();
  tick_set_ctrl #(.CLK_HZ(20), .TICK_HZ(1), .DB_CYCLES(DB), .NFIELD(NF), .BLINK_DIV(BD),
                  .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle-time %0t", name, act, exp, $time);
    end
  endtask
  // reference model: positions in time computed from cycle counts and sample histories
  int m_n, m_anchor, m_entry, m_fld, m_efld;
  int m_last [2];
  bit m_set, m_pulse;
  bit m_db [2], m_ev [2];
  bit rawm [$], rawi [$];
`ifdef AUTO_REPEAT_EN
  bit m_ract;
  int m_rp;
`endif
  function automatic bit s2v(int b, int c);
    if (c < 2) return 1'b0;
    return b == 1 ? rawi[c-2] : rawm[c-2];
  endfunction
  task automatic model_reset();
    m_n = 0; m_anchor = 0; m_entry = 0; m_fld = 0; m_efld = 0; m_set = 0; m_pulse = 0;
    rawm.delete(); rawi.delete();
    for (int b = 0; b < 2; b++) begin m_db[b] = 0; m_ev[b] = 0; m_last[b] = 0; end
`ifdef AUTO_REPEAT_EN
    m_ract = 0; m_rp = 0;
`endif
  endtask
  task automatic model_step();
    bit mev, iev, all;
    m_n++;
    mev = m_ev[0];
    iev = m_ev[1];
    m_pulse = 0;
`ifdef AUTO_REPEAT_EN
    if (m_ract && m_set && m_db[1] && !mev && m_n - m_rp >= RD && (m_n - m_rp - RD) % RP == 0) m_pulse = 1;
    if (!m_db[1] || mev || !m_set) m_ract = 0;
    if (m_set && iev && !mev) begin m_ract = 1; m_rp = m_n; end
`endif
    if (m_set && iev && !mev) m_pulse = 1;
    m_efld = m_fld;
    if (mev) begin
      m_entry = m_n;
      if (!m_set) begin m_set = 1; m_fld = 0; end
      else if (m_fld == NF - 1) begin m_set = 0; m_fld = 0; m_anchor = m_n; end
      else m_fld++;
    end
    rawm.push_back(!bus.btn_mode_n_i);
    rawi.push_back(!bus.btn_inc_n_i);
    for (int b = 0; b < 2; b++) begin
      m_ev[b] = 0;
      if (m_n - DB >= m_last[b]) begin
        all = 1;
        for (int k = 1; k <= DB; k++) if (s2v(b, m_n - k) == m_db[b]) all = 0;
        if (all) begin m_db[b] = !m_db[b]; m_last[b] = m_n; m_ev[b] = m_db[b]; end
      end
    end
  endtask
  function automatic logic [11:0] exp_pack();
    logic t, bl;
    logic [NF-1:0] en;
    t  = (m_n - m_anchor) % DIV == DIV - 1;
    en = !m_set ? NF'(t) : m_pulse ? NF'(1 << m_efld) : '0;
    bl = m_set && ((m_n - m_entry) / BD) % 2 == 1;
    return {t, en, m_set, m_set ? 3'(m_fld) : 3'd0, bl};
  endfunction
  always @(posedge clk)
    if (!reset_n) model_reset();
    else model_step();
  // monitor: every cycle against the model, plus statistics for the directed checks
  int pulse_cnt = 0, pulse_mask = 0, fall_cyc = -1, after_tick = -1;
  int tick_q [$];
  bit prev_set = 0;
  always @(negedge clk) begin
    if (!reset_n) check("reset_outputs", {bus.tick_o, bus.en_field_o, bus.set_mode_o, bus.sel_field_o, bus.blink_o}, 0);
    else begin
      check("outputs", {bus.tick_o, bus.en_field_o, bus.set_mode_o, bus.sel_field_o, bus.blink_o}, exp_pack());
      if (bus.tick_o) tick_q.push_back(m_n);
      if (bus.set_mode_o && bus.en_field_o != 0) begin pulse_cnt++; pulse_mask |= int'(bus.en_field_o); end
      if (prev_set && !bus.set_mode_o) begin fall_cyc = m_n; after_tick = -1; end
      if (fall_cyc >= 0 && after_tick < 0 && bus.tick_o) after_tick = m_n;
    end
    prev_set = bus.set_mode_o;
  end
  task automatic cycles(int k);
    repeat (k) @(posedge clk);
    #2;
  endtask
  task automatic press(int btn, int hold, int gap);
    bus.btn_mode_n_i = btn == 1;
    bus.btn_inc_n_i  = btn == 0;
    cycles(hold);
    bus.btn_mode_n_i = 1'b1;
    bus.btn_inc_n_i  = 1'b1;
    cycles(gap);
  endtask
  typedef struct {int btn; int hold; int exp_set; int exp_sel; int exp_cnt; int exp_mask;} vec_t;
  vec_t tbl [NT];
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int start;
    tbl[0]  = '{1, 8, 1, 0, 1, 1};
    tbl[1]  = '{1, 8, 1, 0, 1, 1};
    tbl[2]  = '{1, 8, 1, 0, 1, 1};
    tbl[3]  = '{1, 2, 1, 0, 0, 0};
    tbl[4]  = '{0, 8, 1, 1, 0, 0};
    tbl[5]  = '{1, 8, 1, 1, 1, 2};
    tbl[6]  = '{0, 8, 1, 2, 0, 0};
    tbl[7]  = '{2, 8, 1, 3, 0, 0};
    tbl[8]  = '{0, 8, 1, 4, 0, 0};
    tbl[9]  = '{1, 8, 1, 4, 1, 16};
    tbl[10] = '{0, 8, 1, 5, 0, 0};
    tbl[11] = '{1, 8, 1, 5, 1, 32};
    tbl[12] = '{0, 8, 0, 0, 0, 0};
    bus.btn_mode_n_i = 1'b1;
    bus.btn_inc_n_i  = 1'b1;
    cycles(3);
    check("rst_tick", bus.tick_o, 0);
    check("rst_en_field", bus.en_field_o, 0);
    check("rst_set_mode", bus.set_mode_o, 0);
    check("rst_sel_field", bus.sel_field_o, 0);
    check("rst_blink", bus.blink_o, 0);
    reset_n = 1'b1;
    tick_q.delete();
    cycles(60);
    check("run_tick_count", tick_q.size(), 3);
    for (int i = 0; i < tick_q.size() && i < 3; i++) check("run_tick_cycle", tick_q[i], 19 + 20 * i);
    check("run_set_mode", bus.set_mode_o, 0);
    pulse_cnt = 0;
    start = m_n;
    bus.btn_mode_n_i = 1'b0;
    for (int i = 0; i < 40 && !bus.set_mode_o; i++) @(negedge clk);
    check("mode_latency", m_n - start, 7);
    cycles(3);
    bus.btn_mode_n_i = 1'b1;
    cycles(10);
    check("set0_sel", bus.sel_field_o, 0);
    check("set0_no_tick_pulse", pulse_cnt, 0);
    for (int i = 0; i < NT; i++) begin
      pulse_cnt = 0;
      pulse_mask = 0;
      press(tbl[i].btn, tbl[i].hold, 12);
      check($sformatf("tbl%0d_set_mode", i), bus.set_mode_o, tbl[i].exp_set);
      check($sformatf("tbl%0d_sel_field", i), bus.sel_field_o, tbl[i].exp_sel);
      check($sformatf("tbl%0d_pulses", i), pulse_cnt, tbl[i].exp_cnt);
      check($sformatf("tbl%0d_mask", i), pulse_mask, tbl[i].exp_mask);
    end
    for (int i = 0; i < 40 && after_tick < 0; i++) @(negedge clk);
    check("tick_after_run", after_tick - fall_cyc, 19);
    cycles(1);
    press(0, 8, 12);
    press(0, 8, 12);
    check("set1_sel", bus.sel_field_o, 1);
`ifdef AUTO_REPEAT_EN
    pulse_cnt = 0;
    pulse_mask = 0;
    press(1, 30, 12);
    check("repeat_pulses", pulse_cnt, 6);
    check("repeat_mask", pulse_mask, 2);
`endif
    bus.btn_inc_n_i = 1'b0;
    cycles(15);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_set_mode", bus.set_mode_o, 0);
    check("midrst_en_field", bus.en_field_o, 0);
    check("midrst_blink", bus.blink_o, 0);
    cycles(2);
    reset_n = 1'b1;
    cycles(3);
    bus.btn_inc_n_i = 1'b1;
    cycles(15);
    check("midrst_run", bus.set_mode_o, 0);
    for (int i = 0; i < 300; i++) begin
      bus.btn_mode_n_i = $urandom_range(0, 3) != 0;
      bus.btn_inc_n_i  = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 99) == 0) begin
        reset_n = 1'b0;
        cycles(2);
        reset_n = 1'b1;
      end
      cycles($urandom_range(1, 12));
    end
    bus.btn_mode_n_i = 1'b1;
    bus.btn_inc_n_i  = 1'b1;
    cycles(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
